// File: rtl/src_ctrl_seq.sv
// Sample-rate-converter state sequencer: MAC tap loop, L/M phase accumulator and stream handshakes.
// Optional stall counters are built when SRC_STALL_CNT_EN is defined; otherwise stall_out/stall_in are tied to 0.
module src_ctrl_seq #(
    parameter int NTAPS    = 8,
    parameter int CNT_W    = 4,
    parameter int L_FACTOR = 3,
    parameter int M_FACTOR = 2,
    parameter int PH_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic [3:0]       fsm_state,
    output logic             in_ack,
    output logic             out_valid,
    output logic [PH_W-1:0]  phase,
    output logic [CNT_W-1:0] tap_idx,
    output logic             busy,
    output logic [15:0]      stall_out,
    output logic [15:0]      stall_in
);

    // state | meaning
    // S0    | idle, waiting for en
    // S1    | fetch
    // S2    | accumulator init, load tap counter
    // S3    | MAC count, NTAPS cycles
    // S4    | result
    // S5    | write back
    // S6    | present output, wait for out_ready
    // S7    | consume input(s) until phase < L
    // S8    | next, sample en
    localparam logic [3:0] S0 = 4'd0;
    localparam logic [3:0] S1 = 4'd1;
    localparam logic [3:0] S2 = 4'd2;
    localparam logic [3:0] S3 = 4'd3;
    localparam logic [3:0] S4 = 4'd4;
    localparam logic [3:0] S5 = 4'd5;
    localparam logic [3:0] S6 = 4'd6;
    localparam logic [3:0] S7 = 4'd7;
    localparam logic [3:0] S8 = 4'd8;

    localparam logic [PH_W:0]    L_EXT    = (PH_W+1)'(L_FACTOR);
    localparam logic [PH_W:0]    M_EXT    = (PH_W+1)'(M_FACTOR);
    localparam logic [CNT_W-1:0] TAP_LAST = CNT_W'(NTAPS - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] tap_q, tap_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [PH_W:0]    ph_add, ph_sub;

    // One extra bit so the add and subtract never wrap.
    assign ph_add = {1'b0, phase_q} + M_EXT;
    assign ph_sub = {1'b0, phase_q} - L_EXT;

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        phase_d = phase_q;
        case (state_q)
            S0: if (en) state_d = S1;
            S1: state_d = S2;
            S2: begin
                tap_d   = TAP_LAST;
                state_d = S3;
            end
            S3: begin
                if (tap_q == '0) state_d = S4;
                else             tap_d   = tap_q - 1'b1;
            end
            S4: state_d = S5;
            S5: state_d = S6;
            S6: begin
                if (out_ready) begin
                    phase_d = ph_add[PH_W-1:0];
                    state_d = (ph_add >= L_EXT) ? S7 : S8;
                end
            end
            S7: begin
                if (in_valid) begin
                    phase_d = ph_sub[PH_W-1:0];
                    state_d = (ph_sub >= L_EXT) ? S7 : S8;
                end
            end
            S8: state_d = en ? S1 : S0;
            default: state_d = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
            tap_q   <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            phase_q <= phase_d;
        end
    end

    assign fsm_state = state_q;
    assign tap_idx   = tap_q;
    assign phase     = phase_q;
    assign out_valid = (state_q == S6);
    assign in_ack    = (state_q == S7) && in_valid;
    assign busy      = (state_q != S0) && (state_q <= S8);

`ifdef SRC_STALL_CNT_EN
    logic [15:0] stall_out_q, stall_in_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_out_q <= '0;
            stall_in_q  <= '0;
        end else begin
            if ((state_q == S6) && !out_ready && (stall_out_q != 16'hFFFF))
                stall_out_q <= stall_out_q + 16'd1;
            if ((state_q == S7) && !in_valid && (stall_in_q != 16'hFFFF))
                stall_in_q <= stall_in_q + 16'd1;
        end
    end

    assign stall_out = stall_out_q;
    assign stall_in  = stall_in_q;
`else
    assign stall_out = '0;
    assign stall_in  = '0;
`endif

endmodule

// File: tb/tb_src_ctrl_seq.sv
// Bench for src_ctrl_seq: two instances (L=3/M=2 and L=2/M=5), per-output transaction model
// expanded into expected per-cycle traces, with directed and randomized stall/enable stimulus.
module tb_src_ctrl_seq;

    logic        clk;
    logic        rst;
    logic        en        [2];
    logic        in_valid  [2];
    logic        out_ready [2];
    logic [3:0]  fsm_state [2];
    logic        in_ack    [2];
    logic        out_valid [2];
    logic [3:0]  phase     [2];
    logic [3:0]  tap_idx   [2];
    logic        busy      [2];
    logic [15:0] stall_out [2];
    logic [15:0] stall_in  [2];

    int vectors;
    int miscompares;

    src_ctrl_seq #(.NTAPS(2), .CNT_W(4), .L_FACTOR(3), .M_FACTOR(2), .PH_W(4)) dut0 (
        .clk(clk), .rst(rst), .en(en[0]), .in_valid(in_valid[0]), .out_ready(out_ready[0]),
        .fsm_state(fsm_state[0]), .in_ack(in_ack[0]), .out_valid(out_valid[0]),
        .phase(phase[0]), .tap_idx(tap_idx[0]), .busy(busy[0]),
        .stall_out(stall_out[0]), .stall_in(stall_in[0])
    );

    src_ctrl_seq #(.NTAPS(4), .CNT_W(4), .L_FACTOR(2), .M_FACTOR(5), .PH_W(4)) dut1 (
        .clk(clk), .rst(rst), .en(en[1]), .in_valid(in_valid[1]), .out_ready(out_ready[1]),
        .fsm_state(fsm_state[1]), .in_ack(in_ack[1]), .out_valid(out_valid[1]),
        .phase(phase[1]), .tap_idx(tap_idx[1]), .busy(busy[1]),
        .stall_out(stall_out[1]), .stall_in(stall_in[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int st;
        int tap;
        int ph;
        bit iv;
        bit ord;
        bit en;
        bit so_inc;
        bit si_inc;
        bit rst;
    } cyc_t;

    cyc_t plan[$];
    int   m_phase [2];
    int   m_so    [2];
    int   m_si    [2];

    function automatic int nt_of(int i); return (i == 0) ? 2 : 4; endfunction
    function automatic int l_of(int i);  return (i == 0) ? 3 : 2; endfunction
    function automatic int m_of(int i);  return (i == 0) ? 2 : 5; endfunction
    function automatic bit rb(); return 1'($urandom_range(0, 1)); endfunction

    function automatic int exp_stall(int v);
`ifdef SRC_STALL_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic push(int st, int tap, int ph, bit iv, bit ord, bit e, bit so_inc, bit si_inc, bit r);
        cyc_t c;
        c.st = st; c.tap = tap; c.ph = ph; c.iv = iv; c.ord = ord; c.en = e;
        c.so_inc = so_inc; c.si_inc = si_inc; c.rst = r;
        plan.push_back(c);
    endtask

    // One output transaction from S1 through S8: en_mid < 0 drives en randomly while it is ignored.
    task automatic build_output(int i, int ostall, int istall, int en_mid, bit en_last);
        int cur;
        int p;
        bit em;
        cur = m_phase[i];
        em  = (en_mid != 0);
        push(1, 0, cur, rb(), rb(), (en_mid < 0) ? rb() : em, 0, 0, 0);
        push(2, 0, cur, rb(), rb(), (en_mid < 0) ? rb() : em, 0, 0, 0);
        for (int k = 0; k < nt_of(i); k++)
            push(3, nt_of(i) - 1 - k, cur, rb(), rb(), (en_mid < 0) ? rb() : em, 0, 0, 0);
        push(4, 0, cur, rb(), rb(), (en_mid < 0) ? rb() : em, 0, 0, 0);
        push(5, 0, cur, rb(), rb(), (en_mid < 0) ? rb() : em, 0, 0, 0);
        for (int k = 0; k < ostall; k++)
            push(6, 0, cur, rb(), 1'b0, (en_mid < 0) ? rb() : em, 1, 0, 0);
        push(6, 0, cur, rb(), 1'b1, (en_mid < 0) ? rb() : em, 0, 0, 0);
        p = cur + m_of(i);
        while (p >= l_of(i)) begin
            for (int k = 0; k < istall; k++)
                push(7, 0, p, 1'b0, rb(), (en_mid < 0) ? rb() : em, 0, 1, 0);
            push(7, 0, p, 1'b1, rb(), (en_mid < 0) ? rb() : em, 0, 0, 0);
            p = p - l_of(i);
        end
        push(8, 0, p, rb(), rb(), en_last, 0, 0, 0);
        m_phase[i] = p;
    endtask

    task automatic exec(int i);
        int n;
        n = 0;
        while (plan.size() > 0) begin
            cyc_t c;
            c = plan.pop_front();
            @(posedge clk);
            #1;
            rst          = c.rst;
            en[i]        = c.en;
            in_valid[i]  = c.iv;
            out_ready[i] = c.ord;
            #2;
            vectors += 8;
            if (fsm_state[i] !== 4'(c.st)) begin
                miscompares++;
                $display("FAIL state inst%0d step%0d got %0d want %0d", i, n, fsm_state[i], c.st);
            end
            if (tap_idx[i] !== 4'(c.tap)) begin
                miscompares++;
                $display("FAIL tap_idx inst%0d step%0d got %0d want %0d", i, n, tap_idx[i], c.tap);
            end
            if (phase[i] !== 4'(c.ph)) begin
                miscompares++;
                $display("FAIL phase inst%0d step%0d got %0d want %0d", i, n, phase[i], c.ph);
            end
            if (in_ack[i] !== ((c.st == 7) && c.iv)) begin
                miscompares++;
                $display("FAIL in_ack inst%0d step%0d got %0b state %0d in_valid %0b", i, n, in_ack[i], c.st, c.iv);
            end
            if (out_valid[i] !== (c.st == 6)) begin
                miscompares++;
                $display("FAIL out_valid inst%0d step%0d got %0b state %0d", i, n, out_valid[i], c.st);
            end
            if (busy[i] !== (c.st != 0)) begin
                miscompares++;
                $display("FAIL busy inst%0d step%0d got %0b state %0d", i, n, busy[i], c.st);
            end
            if (stall_out[i] !== 16'(exp_stall(m_so[i]))) begin
                miscompares++;
                $display("FAIL stall_out inst%0d step%0d got %0d want %0d", i, n, stall_out[i], exp_stall(m_so[i]));
            end
            if (stall_in[i] !== 16'(exp_stall(m_si[i]))) begin
                miscompares++;
                $display("FAIL stall_in inst%0d step%0d got %0d want %0d", i, n, stall_in[i], exp_stall(m_si[i]));
            end
            if (c.so_inc) m_so[i]++;
            if (c.si_inc) m_si[i]++;
            if (c.rst) begin
                m_so[0] = 0; m_so[1] = 0;
                m_si[0] = 0; m_si[1] = 0;
            end
            n++;
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            vectors += 4;
            if (fsm_state[i] !== 4'd0 || busy[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state inst%0d got %0d busy %0b want 0", i, fsm_state[i], busy[i]);
            end
            if (phase[i] !== 4'd0 || tap_idx[i] !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_regs inst%0d phase %0d tap %0d want 0", i, phase[i], tap_idx[i]);
            end
            if (in_ack[i] !== 1'b0 || out_valid[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hs inst%0d in_ack %0b out_valid %0b want 0", i, in_ack[i], out_valid[i]);
            end
            if (stall_out[i] !== 16'd0 || stall_in[i] !== 16'd0) begin
                miscompares++;
                $display("FAIL reset_stall inst%0d got %0d/%0d want 0", i, stall_out[i], stall_in[i]);
            end
        end
    endtask

    // L=3 M=2: phases 2,1,0; the first output skips S7.
    task automatic test_phase_skip();
        push(0, 0, m_phase[0], rb(), rb(), 1'b1, 0, 0, 0);
        build_output(0, 0, 0, -1, 1'b1);
        build_output(0, 0, 0, -1, 1'b1);
        build_output(0, 0, 0, -1, 1'b0);
        push(0, 0, m_phase[0], rb(), rb(), 1'b0, 0, 0, 0);
        exec(0);
    endtask

    // L=2 M=5: first output consumes 2 inputs, second consumes 3.
    task automatic test_multi_input();
        push(0, 0, m_phase[1], rb(), rb(), 1'b1, 0, 0, 0);
        build_output(1, 0, 0, -1, 1'b1);
        build_output(1, 0, 0, -1, 1'b0);
        push(0, 0, m_phase[1], rb(), rb(), 1'b0, 0, 0, 0);
        exec(1);
    endtask

    task automatic test_stalls();
        push(0, 0, m_phase[0], rb(), rb(), 1'b1, 0, 0, 0);
        build_output(0, 0, 0, -1, 1'b1);
        build_output(0, 5, 3, -1, 1'b0);
        push(0, 0, m_phase[0], rb(), rb(), 1'b0, 0, 0, 0);
        exec(0);
    endtask

    task automatic test_reset_mid_loop();
        push(0, 0, m_phase[1], rb(), rb(), 1'b1, 0, 0, 0);
        build_output(1, 1, 1, -1, 1'b1);
        push(1, 0, m_phase[1], rb(), rb(), rb(), 0, 0, 0);
        push(2, 0, m_phase[1], rb(), rb(), rb(), 0, 0, 0);
        push(3, 3, m_phase[1], rb(), rb(), rb(), 0, 0, 0);
        push(3, 2, m_phase[1], rb(), rb(), rb(), 0, 0, 1);
        m_phase[0] = 0;
        m_phase[1] = 0;
        push(0, 0, 0, rb(), rb(), 1'b1, 0, 0, 0);
        build_output(1, 0, 0, -1, 1'b0);
        push(0, 0, m_phase[1], rb(), rb(), 1'b0, 0, 0, 0);
        exec(1);
    endtask

    task automatic test_en_drop();
        push(0, 0, m_phase[1], rb(), rb(), 1'b1, 0, 0, 0);
        build_output(1, 0, 0, 0, 1'b0);
        push(0, 0, m_phase[1], rb(), rb(), 1'b0, 0, 0, 0);
        push(0, 0, m_phase[1], rb(), rb(), 1'b0, 0, 0, 0);
        exec(1);
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++) begin
            int i;
            int n;
            i = int'($urandom_range(0, 1));
            n = int'($urandom_range(1, 4));
            push(0, 0, m_phase[i], rb(), rb(), 1'b1, 0, 0, 0);
            for (int k = 0; k < n; k++)
                build_output(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1, k != n - 1);
            push(0, 0, m_phase[i], rb(), rb(), 1'b0, 0, 0, 0);
            exec(i);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        for (int i = 0; i < 2; i++) begin
            en[i]        = 1'b0;
            in_valid[i]  = 1'b1;
            out_ready[i] = 1'b1;
            m_phase[i]   = 0;
            m_so[i]      = 0;
            m_si[i]      = 0;
        end
        repeat (3) @(posedge clk);
        test_reset();
        test_phase_skip();
        test_multi_input();
        test_stalls();
        test_reset_mid_loop();
        test_en_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
